led_mode_sequencer: RTL and testbench

- Board-level controller that owns the two user LEDs and sequences them through selectable blink patterns.
- A single push-button (raw, active-low, bouncy) steps through the modes.
- A free-running prescaler generates the pattern time base.
- Sits between the board key/LED pins and the rest of the design. It also exports its tick and current mode for other blocks.

---
 rtl/led_mode_sequencer.sv | 125 ++++++++++++
 tb/tb_led_mode_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: debounces a raw active-low key, steps through four
// blink modes on each press, and drives two LEDs from a prescaled time base.
// The current mode and the pattern tick are exported for other blocks.
module led_mode_sequencer #(
  parameter int TICK_CNT     = 25000000,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_n,
  output logic [1:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int TW = $clog2(TICK_CNT);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_BOTH  = 2'd2,
    MODE_CHASE = 2'd3
  } mode_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    phase_q, phase_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    led_q, led_d;

  // All state; async reset puts the key path in the released state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_cnt_q  <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 2'd0;
      mode_q     <= MODE_OFF;
      led_q      <= 2'b00;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
    end
  end

  // Two-flop synchroniser for the asynchronous key input.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // Debounce: accept a new level after DEBOUNCE_CNT consecutive differing
  // samples; a press is the accepted 1->0 transition itself.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    press     = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        press = ~sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Time base, phase and mode FSM; a press restarts the pattern at phase 0
  // and takes priority over a simultaneous tick.
  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    phase_d    = tick ? phase_q + 2'd1 : phase_q;
    if (press) begin
      tick_cnt_d = '0;
      phase_d    = 2'd0;
      case (mode_q)
        MODE_OFF:   mode_d = MODE_ALT;
        MODE_ALT:   mode_d = MODE_BOTH;
        MODE_BOTH:  mode_d = MODE_CHASE;
        MODE_CHASE: mode_d = MODE_OFF;
        default:    mode_d = MODE_OFF;
      endcase
    end
  end

  // LED pattern decode from the current mode and phase (registered output).
  always_comb begin
    led_d = 2'b00;
    case (mode_q)
      MODE_OFF:   led_d = 2'b00;
      MODE_ALT:   led_d = phase_q[0] ? 2'b10 : 2'b01;
      MODE_BOTH:  led_d = phase_q[0] ? 2'b00 : 2'b11;
      MODE_CHASE: begin
        case (phase_q)
          2'd0:    led_d = 2'b01;
          2'd1:    led_d = 2'b11;
          2'd2:    led_d = 2'b10;
          default: led_d = 2'b00;
        endcase
      end
      default:    led_d = 2'b00;
    endcase
  end

  assign tick = (tick_cnt_q == TICK_LAST);
  assign mode = mode_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomised scoreboard bench for led_mode_sequencer with a small time base.
module tb_led_mode_sequencer;

  localparam int T = 4;
  localparam int D = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_n;
  logic [1:0] led;
  logic [1:0] mode;
  logic       tick;

  led_mode_sequencer #(
    .TICK_CNT    (T),
    .DEBOUNCE_CNT(D)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_n),
    .led      (led),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] mode;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: key history, accepted level with a run length,
  // and cycles elapsed since the pattern last restarted.
  bit          pipe[$];
  bit          acc;
  int          run;
  int unsigned since;
  int          m_mode;
  int          m_led;
  int          presses;
  int          press_on_tick;

  function automatic void model_reset();
    pipe   = '{1'b1, 1'b1};
    acc    = 1'b1;
    run    = 0;
    since  = 0;
    m_mode = 0;
    m_led  = 0;
  endfunction

  function automatic int phase_of();
    return int'((since / T) % 4);
  endfunction

  function automatic int decode(int md, int ph);
    case (md)
      1:       return (ph % 2 == 0) ? 1 : 2;
      2:       return (ph % 2 == 0) ? 3 : 0;
      3: begin
        case (ph)
          0:       return 1;
          1:       return 3;
          2:       return 2;
          default: return 0;
        endcase
      end
      default: return 0;
    endcase
  endfunction

  // One active clock edge with key level k present at that edge.
  function automatic void model_step(bit k);
    bit seen;
    bit pr = 1'b0;
    int old_mode  = m_mode;
    int old_phase = phase_of();
    pipe.push_back(k);
    seen = pipe.pop_front();
    if (seen != acc) begin
      run++;
      if (run == D) begin
        acc = seen;
        run = 0;
        pr  = (seen == 1'b0);
      end
    end else begin
      run = 0;
    end
    m_led = decode(old_mode, old_phase);
    if (pr) begin
      presses++;
      if (since % T == T - 1) press_on_tick++;
      m_mode = (m_mode + 1) % 4;
      since  = 0;
    end else begin
      since++;
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    if (!sys_rst_n) model_reset();
    e.led  = m_led[1:0];
    e.mode = m_mode[1:0];
    e.tick = (since % T == T - 1);
    exp_q.push_back(e);
  endfunction

  task automatic check_reset_state();
    checks++;
    if (led !== 2'b00 || mode !== 2'd0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset state cyc=%0d led=%b mode=%0d tick=%b required led=00 mode=0 tick=0",
               cyc, led, mode, tick);
    end
  endtask

  // Monitor: compare DUT outputs on the falling edge against the scoreboard.
  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({led, mode, tick} !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d led=%b mode=%0d tick=%b required led=%b mode=%0d tick=%b",
                 cyc, led, mode, tick, e.led, e.mode, e.tick);
      end
    end
  end

  initial begin
    int  seg_left;
    bit  key_lvl;
    int  r;
    int  rst_hold;
    bit  chase_done;
    bit  rst_new;
    presses       = 0;
    press_on_tick = 0;
    sys_rst_n     = 1'b0;
    key_n         = 1'b1;
    key_lvl       = 1'b1;
    seg_left      = 0;
    rst_hold      = 0;
    chase_done    = 1'b0;
    model_reset();

    repeat (5) begin
      @(posedge sys_clk);
      #1;
      check_reset_state();
      push_exp();
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    push_exp();

    // Idle with key released: mode stays OFF, tick free-runs.
    repeat (12) begin
      @(posedge sys_clk);
      if (sys_rst_n) model_step(key_n);
      #1;
      push_exp();
    end

    for (int i = 0; i < 3000; i++) begin
      @(posedge sys_clk);
      if (sys_rst_n) model_step(key_n);
      #1;
      rst_new = 1'b0;
      if (seg_left == 0) begin
        key_lvl  = ~key_lvl;
        r        = int'($urandom_range(0, 9));
        seg_left = (r < 4) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
      end
      seg_left--;
      key_n = key_lvl;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) sys_rst_n = 1'b1;
      end else if (!chase_done && i > 300 && m_mode == 3 && m_led == 3) begin
        sys_rst_n  = 1'b0;
        rst_hold   = int'($urandom_range(1, 4));
        chase_done = 1'b1;
        rst_new    = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        sys_rst_n = 1'b0;
        rst_hold  = int'($urandom_range(1, 4));
        rst_new   = 1'b1;
      end
      if (rst_new) begin
        #1;
        check_reset_state();
      end
      push_exp();
    end

    @(negedge sys_clk);
    #1;
    checks++;
    if (presses == 0) begin
      failures++;
      $display("FAIL wait expired: no press event accepted within the run");
    end
    $display("info: presses=%0d press_on_tick=%0d chase_reset=%0d",
             presses, press_on_tick, chase_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
